sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_conditioner_pkg.sv | 26 ++
 rtl/sensor_conditioner_if.sv | 36 +++
 rtl/sensor_channel_filter.sv | 89 ++++++++
 rtl/sensor_conditioner.sv | 79 +++++++
 tb/tb_sensor_conditioner.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/sensor_conditioner_pkg.sv
// Shared defaults, channel indices and sizing helper for the sensor conditioner
// and any display logic that decodes its fault vector.
package sensor_conditioner_pkg;

    localparam int DEF_SAMPLE_DIV    = 50000;
    localparam int DEF_STABLE_COUNT  = 8;
    localparam int DEF_FAULT_WINDOW  = 64;
    localparam int DEF_FAULT_TOGGLES = 4;

    localparam int NUM_CH     = 3;
    localparam int FAULT_SOIL = 0;
    localparam int FAULT_AIR  = 1;
    localparam int FAULT_TEMP = 2;

    typedef struct packed {
        logic temp;
        logic air;
        logic soil;
    } ch_bits_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Raw comparator inputs and conditioned outputs of the sensor conditioner.
// The raw levels are asynchronous; all outputs are registered on clk_50mhz.
interface sensor_conditioner_if;

    logic       soil_raw;
    logic       air_raw;
    logic       temp_raw;
    logic       soil_humidity_o;
    logic       air_humidity_o;
    logic       temperature_o;
    logic       change_pulse;
    logic [2:0] sensor_fault;

    modport master (
        output soil_raw,
        output air_raw,
        output temp_raw,
        input  soil_humidity_o,
        input  air_humidity_o,
        input  temperature_o,
        input  change_pulse,
        input  sensor_fault
    );

    modport slave (
        input  soil_raw,
        input  air_raw,
        input  temp_raw,
        output soil_humidity_o,
        output air_humidity_o,
        output temperature_o,
        output change_pulse,
        output sensor_fault
    );

endinterface

// File: rtl/sensor_channel_filter.sv
// One sensor channel: 2-flop synchronizer, tick-driven stability filter and
// windowed toggle counter that freezes the filtered level while faulty.
module sensor_channel_filter
    import sensor_conditioner_pkg::*;
#(
    parameter int STABLE_COUNT  = DEF_STABLE_COUNT,
    parameter int FAULT_TOGGLES = DEF_FAULT_TOGGLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic tick_i,
    input  logic window_end_i,
    output logic filt_o,
    output logic flip_o,
    output logic fault_o
);

    localparam int SW = cnt_width(STABLE_COUNT);
    localparam int TW = $clog2(FAULT_TOGGLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          prev_q,  prev_d;
    logic          filt_q,  filt_d;
    logic          fault_q, fault_d;
    logic [SW-1:0] stab_q,  stab_d;
    logic [TW-1:0] tog_q,   tog_d;
    logic [TW-1:0] tog_incl;
    logic          toggled;

    always_comb begin
        prev_d   = prev_q;
        filt_d   = filt_q;
        fault_d  = fault_q;
        stab_d   = stab_q;
        tog_d    = tog_q;
        toggled  = 1'b0;
        tog_incl = tog_q;
        if (tick_i) begin
            prev_d   = sync2_q;
            toggled  = (sync2_q != prev_q);
            // Saturating so a noisy channel cannot wrap back under the threshold.
            tog_incl = (toggled && (tog_q != TW'(FAULT_TOGGLES))) ? tog_q + TW'(1) : tog_q;
            if (window_end_i) begin
                fault_d = (tog_incl >= TW'(FAULT_TOGGLES));
                tog_d   = '0;
            end else begin
                tog_d = tog_incl;
            end

            // The registered fault governs this tick, so a clearing fault
            // only lets filtering resume on the following tick.
            if (fault_q || (sync2_q == filt_q)) begin
                stab_d = '0;
            end else if (stab_q == SW'(STABLE_COUNT - 1)) begin
                filt_d = sync2_q;
                stab_d = '0;
            end else begin
                stab_d = stab_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            filt_q  <= 1'b0;
            fault_q <= 1'b0;
            stab_q  <= '0;
            tog_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            prev_q  <= prev_d;
            filt_q  <= filt_d;
            fault_q <= fault_d;
            stab_q  <= stab_d;
            tog_q   <= tog_d;
        end
    end

    assign filt_o  = filt_q;
    assign flip_o  = (filt_d != filt_q);
    assign fault_o = fault_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces three comparator-level sensors for the irrigation controller and
// flags channels that chatter too often within a fault window.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
    parameter int STABLE_COUNT  = DEF_STABLE_COUNT,
    parameter int FAULT_WINDOW  = DEF_FAULT_WINDOW,
    parameter int FAULT_TOGGLES = DEF_FAULT_TOGGLES
) (
    input  logic               clk_50mhz,
    input  logic               reset,
    sensor_conditioner_if.slave bus
);

    localparam int PW = cnt_width(SAMPLE_DIV);
    localparam int WW = cnt_width(FAULT_WINDOW);

    logic [PW-1:0]     presc_q, presc_d;
    logic [WW-1:0]     win_q,   win_d;
    logic              tick;
    logic              window_end;
    logic              change_pulse_q, change_pulse_d;
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] filt;
    logic [NUM_CH-1:0] flip;
    logic [NUM_CH-1:0] fault;

    assign tick       = (presc_q == PW'(SAMPLE_DIV - 1));
    assign window_end = tick && (win_q == WW'(FAULT_WINDOW - 1));

    always_comb begin
        presc_d        = tick ? '0 : presc_q + PW'(1);
        win_d          = win_q;
        change_pulse_d = |flip;
        if (tick) begin
            win_d = window_end ? '0 : win_q + WW'(1);
        end
    end

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            presc_q        <= '0;
            win_q          <= '0;
            change_pulse_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            win_q          <= win_d;
            change_pulse_q <= change_pulse_d;
        end
    end

    assign raw[FAULT_SOIL] = bus.soil_raw;
    assign raw[FAULT_AIR]  = bus.air_raw;
    assign raw[FAULT_TEMP] = bus.temp_raw;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sensor_channel_filter #(
            .STABLE_COUNT  (STABLE_COUNT),
            .FAULT_TOGGLES (FAULT_TOGGLES)
        ) u_filter (
            .clk_i        (clk_50mhz),
            .rst_i        (reset),
            .raw_i        (raw[g]),
            .tick_i       (tick),
            .window_end_i (window_end),
            .filt_o       (filt[g]),
            .flip_o       (flip[g]),
            .fault_o      (fault[g])
        );
    end

    assign bus.soil_humidity_o = filt[FAULT_SOIL];
    assign bus.air_humidity_o  = filt[FAULT_AIR];
    assign bus.temperature_o   = filt[FAULT_TEMP];
    assign bus.change_pulse    = change_pulse_q;
    assign bus.sensor_fault    = fault;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed scenarios for sensor_conditioner with SAMPLE_DIV=4 (tick on every
// 4th edge after reset release), STABLE_COUNT=3, FAULT_WINDOW=16, FAULT_TOGGLES=4.
module tb_sensor_conditioner;

  // Expected entry: {cycle since reset release[15:0], fault[2:0], temp, air, soil}
  localparam int W = 22;

  logic clk_50mhz = 1'b0;
  logic reset     = 1'b1;
  int   cyc;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]   prev_fault = 3'b000;

  sensor_conditioner_if ifc();

  sensor_conditioner #(
    .SAMPLE_DIV    (4),
    .STABLE_COUNT  (3),
    .FAULT_WINDOW  (16),
    .FAULT_TOGGLES (4)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .bus       (ifc)
  );

  // ---------------- clock / reset ----------------
  always #10 clk_50mhz = ~clk_50mhz;

  always @(posedge clk_50mhz or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] mk(input int c, input logic [2:0] f,
                                      input logic t, input logic a, input logic s);
    return {16'(c), f, t, a, s};
  endfunction

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk_50mhz);
  endtask

  task automatic apply_reset(input logic s, input logic a, input logic t);
    @(negedge clk_50mhz);
    #1 reset = 1'b1;
    ifc.soil_raw = s;
    ifc.air_raw  = a;
    ifc.temp_raw = t;
    repeat (3) @(negedge clk_50mhz);
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {26'd0, ifc.sensor_fault, ifc.temperature_o, ifc.air_humidity_o,
                 ifc.soil_humidity_o, ifc.change_pulse}, 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // An event is any cycle with change_pulse high or a sensor_fault change.
  always @(negedge clk_50mhz) begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    if (reset) begin
      prev_fault = 3'b000;
    end else begin
      if (ifc.change_pulse || (ifc.sensor_fault != prev_fault)) begin
        got = {16'(cyc), ifc.sensor_fault, ifc.temperature_o, ifc.air_humidity_o,
               ifc.soil_humidity_o};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got=%0h (cyc=%0d) want=none", got, cyc);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL event got=%0h (cyc=%0d) want=%0h (cyc=%0d)",
                     got, cyc, want, want[21:6]);
          end
        end
      end
      prev_fault = ifc.sensor_fault;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ifc.soil_raw = 1'b0;
    ifc.air_raw  = 1'b0;
    ifc.temp_raw = 1'b0;
    repeat (2) @(negedge clk_50mhz);
    check_outputs_zero("reset_state");

    // Soil held high through reset: flips on the 3rd tick (edge 12).
    exp_q.push_back(mk(12, 3'b000, 1'b0, 1'b0, 1'b1));
    apply_reset(1'b1, 1'b0, 1'b0);
    go_to(40);
    check("soil_rise_drained", exp_q.size(), 0);
    check("soil_rise_level", {29'd0, ifc.temperature_o, ifc.air_humidity_o, ifc.soil_humidity_o}, 32'd1);

    // Air: 2 ticks high, 1 low, 3 high -> rises only at tick 6.
    exp_q.push_back(mk(24, 3'b000, 1'b0, 1'b1, 1'b0));
    apply_reset(1'b0, 1'b0, 1'b0);
    go_to(1);  ifc.air_raw = 1'b1;
    go_to(9);  ifc.air_raw = 1'b0;
    go_to(13); ifc.air_raw = 1'b1;
    go_to(80);
    check("air_restart_drained", exp_q.size(), 0);

    // Temp chatters every tick for a full window -> fault, frozen, then clears.
    exp_q.push_back(mk(64,  3'b100, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(128, 3'b000, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(140, 3'b000, 1'b1, 1'b0, 1'b0));
    apply_reset(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      go_to(4 * j + 1);
      ifc.temp_raw = ((j + 1) % 2) == 1;
    end
    go_to(65); ifc.temp_raw = 1'b1;
    go_to(100);
    check("temp_frozen", {31'd0, ifc.temperature_o}, 32'd0);
    go_to(200);
    check("temp_fault_drained", exp_q.size(), 0);

    // Soil and air rise together -> same edge, one pulse.
    exp_q.push_back(mk(16, 3'b000, 1'b0, 1'b1, 1'b1));
    apply_reset(1'b0, 1'b0, 1'b0);
    go_to(5); ifc.soil_raw = 1'b1; ifc.air_raw = 1'b1;
    go_to(80);
    check("dual_flip_drained", exp_q.size(), 0);

    // Reset after 2 of 3 stable ticks -> a full 3 ticks needed afterwards.
    apply_reset(1'b1, 1'b0, 1'b0);
    go_to(9);
    #1 reset = 1'b1;
    @(negedge clk_50mhz);
    check_outputs_zero("mid_reset_clear");
    exp_q.push_back(mk(12, 3'b000, 1'b0, 1'b0, 1'b1));
    reset = 1'b0;
    go_to(40);
    check("mid_reset_drained", exp_q.size(), 0);

    // One-cycle glitch between ticks is never sampled.
    exp_q.push_back(mk(20, 3'b000, 1'b0, 1'b0, 1'b1));
    apply_reset(1'b0, 1'b0, 1'b0);
    go_to(6); ifc.soil_raw = 1'b1;
    go_to(7); ifc.soil_raw = 1'b0;
    go_to(8);
    check("glitch_no_effect", {31'd0, ifc.soil_humidity_o}, 32'd0);
    go_to(9); ifc.soil_raw = 1'b1;
    go_to(40);
    check("glitch_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
